// File: rtl/inst_buffer.sv
// Fetch-to-dispatch instruction buffer: a circular FIFO whose early ib_full
// leaves one free slot for the packet fetch already has in flight.
package inst_buffer_pkg;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
    logic        valid;
  } IF_IB_PACKET;
endpackage

module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       squash,
  input  IF_IB_PACKET                if_ib_packet,
  output logic                       ib_full,
  input  logic                       dp_ready,
  output IF_IB_PACKET                ib_dp_packet,
  output logic [$clog2(DEPTH+1)-1:0] ib_count,
  output logic                       ib_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_HI  = CNT_W'(DEPTH-1);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
  } ib_entry_t;

  ib_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             is_full;
  logic             is_empty;
  logic             push;
  logic             pop;
  logic             drop;

  always_comb begin
    is_full  = (count == CNT_MAX);
    is_empty = (count == '0);
    pop      = !is_empty && dp_ready && !squash;
    // A pop in the same cycle frees the head slot, so a full buffer still accepts.
    push     = if_ib_packet.valid && !squash && (!is_full || pop);
    drop     = if_ib_packet.valid && !squash && is_full && !pop;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      ib_overflow <= 1'b0;
    end else if (squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      if (drop) ib_overflow <= 1'b1;
    end
  end

  // Entry contents need no reset; occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (reset && push)
      mem[tail] <= '{inst: if_ib_packet.inst, PC: if_ib_packet.PC, NPC: if_ib_packet.NPC};
  end

  always_comb begin
    ib_dp_packet = '{inst: NOP, PC: 32'h0, NPC: 32'h0, valid: 1'b0};
    if (!is_empty)
      ib_dp_packet = '{inst: mem[head].inst, PC: mem[head].PC, NPC: mem[head].NPC, valid: 1'b1};
  end

  assign ib_full  = (count >= CNT_HI);
  assign ib_count = count;

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: reset, fill with a registered fetch model,
// ordered drain, streaming wrap, squash and overflow.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  logic        clock;
  logic        reset;
  logic        squash;
  logic        dp_ready;
  IF_IB_PACKET if_ib_packet;
  IF_IB_PACKET ib_dp_packet;
  logic        ib_full;
  logic [3:0]  ib_count;
  logic        ib_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  inst_buffer #(.DEPTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .squash       (squash),
    .if_ib_packet (if_ib_packet),
    .ib_full      (ib_full),
    .dp_ready     (dp_ready),
    .ib_dp_packet (ib_dp_packet),
    .ib_count     (ib_count),
    .ib_overflow  (ib_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic sq);
    if_ib_packet = '{inst: pc ^ 32'hA5A5_0000, PC: pc, NPC: pc + 32'd4, valid: v};
    dp_ready     = rdy;
    squash       = sq;
  endtask

  logic        f_v;
  logic [31:0] f_pc;
  logic [31:0] nxt_pc;
  int          exp_cnt;

  initial begin
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b1;

    // reset then idle
    for (int i = 0; i < 5; i++) begin
      check_eq("rst_cnt",   ib_count, 0);
      check_eq("rst_full",  ib_full, 0);
      check_eq("rst_valid", ib_dp_packet.valid, 0);
      check_eq("rst_inst",  ib_dp_packet.inst, NOP);
      check_eq("rst_ovf",   ib_overflow, 0);
      step();
    end

    // fill: fetch registers its packet, so it reacts to ib_full one cycle late
    f_v = 1'b0; f_pc = 32'h0; nxt_pc = 32'h0; exp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      drive(f_v, f_pc, 1'b0, 1'b0);
      check_eq("fill_cnt",  ib_count, 64'(exp_cnt));
      check_eq("fill_full", ib_full, 64'(exp_cnt >= 7));
      if (f_v) exp_cnt++;
      if (!ib_full) begin
        f_v = 1'b1; f_pc = nxt_pc; nxt_pc = nxt_pc + 32'd4;
      end else begin
        f_v = 1'b0;
      end
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("fill_cnt8",  ib_count, 8);
    check_eq("fill_ovf",   ib_overflow, 0);
    check_eq("fill_head",  ib_dp_packet.PC, 32'h0);

    // drain in order
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      check_eq("drain_pc",    ib_dp_packet.PC, 64'(4 * i));
      check_eq("drain_inst",  ib_dp_packet.inst, 64'((4 * i) ^ 32'hA5A5_0000));
      check_eq("drain_valid", ib_dp_packet.valid, 1);
      check_eq("drain_cnt",   ib_count, 64'(8 - i));
      check_eq("drain_full",  ib_full, 64'((8 - i) >= 7));
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("drain_empty", ib_dp_packet.valid, 0);
    check_eq("drain_nop",   ib_dp_packet.inst, NOP);
    check_eq("drain_cnt0",  ib_count, 0);

    // streaming from count=3, wraps the pointers several times
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h10C + 32'(4 * i), 1'b1, 1'b0);
      check_eq("strm_cnt", ib_count, 3);
      check_eq("strm_pc",  ib_dp_packet.PC, 64'(32'h100 + 32'(4 * i)));
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("strm_cnt_end", ib_count, 3);
    check_eq("strm_pc_end",  ib_dp_packet.PC, 32'h150);

    // squash at count=5 with simultaneous push and pop
    drive(1'b1, 32'h200, 1'b0, 1'b0); step();
    drive(1'b1, 32'h204, 1'b0, 1'b0); step();
    check_eq("sq_pre_cnt", ib_count, 5);
    drive(1'b1, 32'hBAD0, 1'b1, 1'b1);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("sq_cnt",   ib_count, 0);
    check_eq("sq_valid", ib_dp_packet.valid, 0);
    check_eq("sq_full",  ib_full, 0);
    step();
    check_eq("sq_still_empty", ib_dp_packet.valid, 0);
    drive(1'b1, 32'h300, 1'b0, 1'b0);
    step();
    check_eq("sq_first_pc", ib_dp_packet.PC, 32'h300);

    // fill to 8 ignoring ib_full, then overflow
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0);
      step();
    end
    check_eq("ovf_pre_cnt", ib_count, 8);
    check_eq("ovf_pre",     ib_overflow, 0);
    drive(1'b1, 32'hDEAD0, 1'b0, 1'b0);
    step();
    check_eq("ovf_cnt",  ib_count, 8);
    check_eq("ovf_flag", ib_overflow, 1);
    check_eq("ovf_head", ib_dp_packet.PC, 32'h300);

    // push and pop together while full
    drive(1'b1, 32'h320, 1'b1, 1'b0);
    step();
    check_eq("fullpp_cnt",  ib_count, 8);
    check_eq("fullpp_head", ib_dp_packet.PC, 32'h304);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      check_eq("ovf_drain_pc", ib_dp_packet.PC, 64'(32'h304 + 32'(4 * i)));
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("ovf_drain_empty", ib_dp_packet.valid, 0);

    drive(1'b0, 32'h0, 1'b0, 1'b1);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("ovf_after_sq", ib_overflow, 1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_eq("ovf_after_rst", ib_overflow, 0);
    check_eq("rst2_cnt",      ib_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
